// File: rtl/tea_sched.sv
// tea_sched: schedules two 4-phase clients onto one shared TEA engine.
// The engine handshake is asynchronous to pclk. eng_ack is synchronized,
// and every handshake phase is bounded by TIMEOUT cycles.
//
// Ports:
//   pclk, prstb             clock (rising edge), async active-low reset
//   c0_req/c1_req           client 4-phase requests
//   c0_wdata/c1_wdata       client input words
//   c0_ack/c1_ack           client 4-phase acknowledges (registered)
//   c0_rdata/c1_rdata       per-client result words (registered)
//   eng_req, eng_wdata      request and input word to the engine (registered)
//   eng_ack, eng_rdata      engine acknowledge (async) and result word
//   err_clr                 clears the sticky timeout flag
//   err                     sticky engine-timeout flag
//   busy                    high whenever the scheduler is not idle
`timescale 1ns/1ps

module tea_sched #(
    parameter logic [15:0] TIMEOUT     = 16'd1023,
    parameter int unsigned SYNC_STAGES = 2          // legal range 2..3
) (
    input  logic        pclk,
    input  logic        prstb,
    input  logic        c0_req,
    input  logic        c1_req,
    input  logic [31:0] c0_wdata,
    input  logic [31:0] c1_wdata,
    output logic        c0_ack,
    output logic        c1_ack,
    output logic [31:0] c0_rdata,
    output logic [31:0] c1_rdata,
    output logic        eng_req,
    output logic [31:0] eng_wdata,
    input  logic        eng_ack,
    input  logic [31:0] eng_rdata,
    input  logic        err_clr,
    output logic        err,
    output logic        busy
);

    localparam int unsigned DW = 32;
    localparam int unsigned TW = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_RELEASE = 2'd2,
        ST_RESP    = 2'd3
    } state_e;

    state_e               state_q;
    logic                 grant_q;        // 0 = c0, 1 = c1
    logic                 last_grant_q;
    logic [TW-1:0]        timer_q;
    logic                 err_q;
    logic                 busy_q;
    logic                 eng_req_q;
    logic [DW-1:0]        eng_wdata_q;
    logic                 c0_ack_q;
    logic                 c1_ack_q;
    logic [DW-1:0]        c0_rdata_q;
    logic [DW-1:0]        c1_rdata_q;
    logic [SYNC_STAGES-1:0] ack_sync_q;

    logic                 ack_s;
    logic [TW-1:0]        timer_inc;
    logic                 timeout_hit;
    logic                 win;
    logic                 req_any;
    logic                 gnt_req;
    logic                 err_set;

    // eng_ack synchronizer; the FSM looks only at the last stage
    always_ff @(posedge pclk or negedge prstb) begin
        if (!prstb) begin
            ack_sync_q <= '0;
        end else begin
            ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], eng_ack};
        end
    end

    assign ack_s = ack_sync_q[SYNC_STAGES-1];

    // Timer and arbitration helpers
    always_comb begin
        timer_inc   = (timer_q == {TW{1'b1}}) ? timer_q : timer_q + TW'(1);
        // Compare the incremented value so a phase lasts exactly TIMEOUT cycles
        timeout_hit = (timer_inc >= TIMEOUT);
        req_any     = c0_req | c1_req;
        // Contention goes to whichever client was not served last
        if (c0_req && c1_req) begin
            win = ~last_grant_q;
        end else begin
            win = c1_req;
        end
        gnt_req = grant_q ? c1_req : c0_req;
        err_set = ((state_q == ST_REQ)     && !ack_s && timeout_hit) ||
                  ((state_q == ST_RELEASE) &&  ack_s && timeout_hit);
    end

    // Scheduler FSM with registered outputs
    always_ff @(posedge pclk or negedge prstb) begin
        if (!prstb) begin
            state_q      <= ST_IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            timer_q      <= '0;
            busy_q       <= 1'b0;
            eng_req_q    <= 1'b0;
            eng_wdata_q  <= '0;
            c0_ack_q     <= 1'b0;
            c1_ack_q     <= 1'b0;
            c0_rdata_q   <= '0;
            c1_rdata_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // Wait for the engine to drop its previous ack before a new request
                    if (req_any && !ack_s) begin
                        grant_q     <= win;
                        eng_wdata_q <= win ? c1_wdata : c0_wdata;
                        timer_q     <= '0;
                        eng_req_q   <= 1'b1;
                        busy_q      <= 1'b1;
                        state_q     <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (ack_s) begin
                        if (grant_q) begin
                            c1_rdata_q <= eng_rdata;
                        end else begin
                            c0_rdata_q <= eng_rdata;
                        end
                        eng_req_q <= 1'b0;
                        timer_q   <= '0;
                        state_q   <= ST_RELEASE;
                    end else if (timeout_hit) begin
                        // Abandon the request; the result word is left untouched
                        eng_req_q <= 1'b0;
                        timer_q   <= '0;
                        state_q   <= ST_RELEASE;
                    end else begin
                        timer_q <= timer_inc;
                    end
                end
                ST_RELEASE: begin
                    if (!ack_s || timeout_hit) begin
                        if (grant_q) begin
                            c1_ack_q <= 1'b1;
                        end else begin
                            c0_ack_q <= 1'b1;
                        end
                        timer_q <= '0;
                        state_q <= ST_RESP;
                    end else begin
                        timer_q <= timer_inc;
                    end
                end
                ST_RESP: begin
                    // A request already dropped early completes here at once
                    if (!gnt_req) begin
                        c0_ack_q     <= 1'b0;
                        c1_ack_q     <= 1'b0;
                        last_grant_q <= grant_q;
                        busy_q       <= 1'b0;
                        state_q      <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Sticky timeout flag; a new timeout beats a simultaneous clear
    always_ff @(posedge pclk or negedge prstb) begin
        if (!prstb) begin
            err_q <= 1'b0;
        end else if (err_set) begin
            err_q <= 1'b1;
        end else if (err_clr) begin
            err_q <= 1'b0;
        end
    end

    assign c0_ack    = c0_ack_q;
    assign c1_ack    = c1_ack_q;
    assign c0_rdata  = c0_rdata_q;
    assign c1_rdata  = c1_rdata_q;
    assign eng_req   = eng_req_q;
    assign eng_wdata = eng_wdata_q;
    assign err       = err_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_tea_sched.sv
// Bench for tea_sched. It uses a scoreboard of expected results per client
// and a loopback engine model. A second instance with TIMEOUT=8 covers the
// timeout behaviour.
`timescale 1ns/1ps

module tb_tea_sched;

    localparam int BOUND = 400;

    logic        pclk = 1'b0;
    logic        prstb;
    logic        c0_req, c1_req, c0_ack, c1_ack, eng_req, eng_ack, err_clr, err, busy;
    logic [31:0] c0_wdata, c1_wdata, c0_rdata, c1_rdata, eng_wdata, eng_rdata;

    logic        t_c0_req, t_c1_req, t_c0_ack, t_c1_ack, t_eng_req, t_eng_ack;
    logic        t_err_clr, t_err, t_busy;
    logic [31:0] t_c0_wdata, t_c1_wdata, t_c0_rdata, t_c1_rdata, t_eng_wdata, t_eng_rdata;

    always #5 pclk = ~pclk;

    tea_sched u_dut (
        .pclk(pclk), .prstb(prstb),
        .c0_req(c0_req), .c1_req(c1_req), .c0_wdata(c0_wdata), .c1_wdata(c1_wdata),
        .c0_ack(c0_ack), .c1_ack(c1_ack), .c0_rdata(c0_rdata), .c1_rdata(c1_rdata),
        .eng_req(eng_req), .eng_wdata(eng_wdata), .eng_ack(eng_ack), .eng_rdata(eng_rdata),
        .err_clr(err_clr), .err(err), .busy(busy)
    );

    tea_sched #(.TIMEOUT(16'd8), .SYNC_STAGES(2)) u_dut_t8 (
        .pclk(pclk), .prstb(prstb),
        .c0_req(t_c0_req), .c1_req(t_c1_req), .c0_wdata(t_c0_wdata), .c1_wdata(t_c1_wdata),
        .c0_ack(t_c0_ack), .c1_ack(t_c1_ack), .c0_rdata(t_c0_rdata), .c1_rdata(t_c1_rdata),
        .eng_req(t_eng_req), .eng_wdata(t_eng_wdata), .eng_ack(t_eng_ack), .eng_rdata(t_eng_rdata),
        .err_clr(t_err_clr), .err(t_err), .busy(t_busy)
    );

    int          checks = 0;
    int          passes = 0;
    logic [31:0] exp_q0[$];
    logic [31:0] exp_q1[$];
    int          grant_log[$];
    bit          pend[2];
    int          waited[2];

    int          eng_delay = 0;      // 0 selects a random 1..20 cycle delay
    bit          eng_fixed = 1'b0;
    logic [31:0] eng_data  = 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic logic ack_of(input int id);
        return (id != 0) ? c1_ack : c0_ack;
    endfunction

    // Loopback engine: result = ~input after a delay; ack drops some time after req drops
    initial begin
        int d;
        int n;
        eng_ack   = 1'b0;
        eng_rdata = 32'h0;
        forever begin
            @(posedge pclk);
            #1;
            if (eng_req === 1'b1) begin
                d = (eng_delay > 0) ? eng_delay : int'($urandom_range(20, 1));
                repeat (d - 1) @(posedge pclk);
                #2;
                eng_rdata = eng_fixed ? eng_data : ~eng_wdata;
                eng_ack   = 1'b1;
                n = 0;
                while (eng_req === 1'b1 && n < 5000) begin
                    @(posedge pclk);
                    n++;
                end
                repeat ($urandom_range(3, 0)) @(posedge pclk);
                #2 eng_ack = 1'b0;
            end
        end
    end

    // Monitor: check results on each ack rise, and check grant choice on each eng_req rise
    initial begin
        logic p0, p1, pe;
        logic [31:0] e;
        int g, o;
        p0 = 1'b0; p1 = 1'b0; pe = 1'b0;
        forever begin
            @(negedge pclk);
            if (prstb === 1'b1) begin
                if (c0_ack && !p0) begin
                    if (exp_q0.size() == 0) chk("c0_unexpected_ack", 32'(c0_ack), 32'd0);
                    else begin e = exp_q0.pop_front(); chk("c0_rdata", c0_rdata, e); end
                end
                if (c1_ack && !p1) begin
                    if (exp_q1.size() == 0) chk("c1_unexpected_ack", 32'(c1_ack), 32'd0);
                    else begin e = exp_q1.pop_front(); chk("c1_rdata", c1_rdata, e); end
                end
                if (eng_req && !pe) begin
                    g = int'(eng_wdata[31]);
                    o = 1 - g;
                    grant_log.push_back(g);
                    chk("eng_wdata_of_grant", eng_wdata, (g != 0) ? c1_wdata : c0_wdata);
                    chk("grant_to_pending", 32'(pend[g]), 32'd1);
                    pend[g]   = 1'b0;
                    waited[g] = 0;
                    if (pend[o]) begin
                        waited[o]++;
                        chk("wait_more_than_one", 32'(waited[o] > 1), 32'd0);
                    end
                end
            end
            p0 = c0_ack; p1 = c1_ack; pe = eng_req;
        end
    end

    // One full 4-phase client transaction on the main instance
    task automatic client_txn(input int id, input logic [31:0] wd, input logic [31:0] ex,
                              input bit lat, input int hold);
        int n;
        @(negedge pclk);
        if (id == 0) begin c0_wdata = wd; exp_q0.push_back(ex); pend[0] = 1'b1; c0_req = 1'b1; end
        else         begin c1_wdata = wd; exp_q1.push_back(ex); pend[1] = 1'b1; c1_req = 1'b1; end
        if (lat) begin
            @(negedge pclk);
            chk("eng_req_latency", 32'(eng_req), 32'd1);
        end
        n = 0;
        while (!ack_of(id) && n < BOUND) begin @(negedge pclk); n++; end
        chk("ack_seen", 32'(ack_of(id)), 32'd1);
        if (hold > 0) begin
            repeat (hold) @(negedge pclk);
            chk("ack_held", 32'(ack_of(id)), 32'd1);
        end
        @(negedge pclk);
        if (id == 0) c0_req = 1'b0; else c1_req = 1'b0;
        n = 0;
        while (ack_of(id) && n < BOUND) begin @(negedge pclk); n++; end
        chk("ack_released", 32'(ack_of(id)), 32'd0);
    endtask

    task automatic client_loop(input int id, input int cnt, input int max_gap);
        logic [31:0] wd;
        for (int i = 0; i < cnt; i++) begin
            if (max_gap > 0) repeat ($urandom_range(max_gap, 0)) @(negedge pclk);
            wd = {id[0], 31'($urandom)};
            client_txn(id, wd, ~wd, 1'b0, 0);
        end
    endtask

    task automatic do_reset();
        @(negedge pclk);
        prstb = 1'b0;
        repeat (2) @(negedge pclk);
        exp_q0.delete(); exp_q1.delete();
        pend[0] = 1'b0; pend[1] = 1'b0; waited[0] = 0; waited[1] = 0;
        prstb = 1'b1;
    endtask

    task automatic t_wait(input int which, input logic level);
        int n;
        n = 0;
        while (n < 60) begin
            case (which)
                0: if (t_eng_req === level) break;
                1: if (t_c0_ack === level) break;
                default: if (t_c1_ack === level) break;
            endcase
            @(negedge pclk);
            n++;
        end
    endtask

    // Watchdog
    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        prstb = 1'b0;
        c0_req = 0; c1_req = 0; c0_wdata = 0; c1_wdata = 0; err_clr = 0;
        t_c0_req = 0; t_c1_req = 0; t_c0_wdata = 0; t_c1_wdata = 0; t_err_clr = 0;
        t_eng_ack = 0; t_eng_rdata = 0;
        pend[0] = 0; pend[1] = 0; waited[0] = 0; waited[1] = 0;
        repeat (3) @(negedge pclk);
        chk("rst_c0_ack", 32'(c0_ack), 0);     chk("rst_c1_ack", 32'(c1_ack), 0);
        chk("rst_c0_rdata", c0_rdata, 0);       chk("rst_c1_rdata", c1_rdata, 0);
        chk("rst_eng_req", 32'(eng_req), 0);   chk("rst_eng_wdata", eng_wdata, 0);
        chk("rst_busy", 32'(busy), 0);         chk("rst_err", 32'(err), 0);
        chk("rst_t_eng_req", 32'(t_eng_req), 0);
        prstb = 1'b1;

        // Single c0 transaction with a 10-cycle engine
        eng_delay = 10; eng_fixed = 1'b1; eng_data = 32'hDEADBEEF;
        client_txn(0, 32'h41424344, 32'hDEADBEEF, 1'b1, 3);
        chk("basic_err", 32'(err), 0);
        chk("basic_c0_rdata_kept", c0_rdata, 32'hDEADBEEF);
        chk("basic_c1_ack", 32'(c1_ack), 0);
        chk("basic_c1_rdata", c1_rdata, 0);
        eng_delay = 0; eng_fixed = 1'b0;

        // Both clients from reset, three transactions each: strict alternation from c0
        do_reset();
        grant_log.delete();
        fork
            client_loop(0, 3, 0);
            client_loop(1, 3, 0);
        join
        chk("alt_grant_count", 32'(grant_log.size()), 32'd6);
        for (int i = 0; i < 6; i++)
            if (i < grant_log.size()) chk("alt_grant_order", 32'(grant_log[i]), 32'(i % 2));

        // Random mixed traffic against the loopback engine
        fork
            client_loop(0, 250, 3);
            client_loop(1, 250, 3);
        join
        chk("rand_err", 32'(err), 0);

        // Reset while a request is outstanding
        eng_delay = 15;
        @(negedge pclk);
        c0_wdata = 32'h01020304; pend[0] = 1'b1; c0_req = 1'b1;
        repeat (3) @(negedge pclk);
        chk("mid_busy", 32'(busy), 1);
        chk("mid_eng_req", 32'(eng_req), 1);
        #2 prstb = 1'b0;
        #1;
        chk("arst_eng_req", 32'(eng_req), 0);  chk("arst_busy", 32'(busy), 0);
        chk("arst_eng_wdata", eng_wdata, 0);   chk("arst_c0_ack", 32'(c0_ack), 0);
        chk("arst_c0_rdata", c0_rdata, 0);     chk("arst_c1_rdata", c1_rdata, 0);
        c0_req = 1'b0; pend[0] = 1'b0;
        repeat (2) @(negedge pclk);
        prstb = 1'b1;
        @(negedge pclk);
        chk("post_rst_idle", 32'(busy), 0);
        repeat (40) @(negedge pclk);
        eng_delay = 0;
        client_txn(1, 32'h80ABCDEF, ~32'h80ABCDEF, 1'b1, 0);
        chk("post_rst_c0_rdata", c0_rdata, 0);
        chk("sb_empty0", 32'(exp_q0.size()), 0);
        chk("sb_empty1", 32'(exp_q1.size()), 0);

        // TIMEOUT=8 instance: one good transaction to set a prior rdata
        @(negedge pclk);
        t_c0_wdata = 32'h11112222; t_c0_req = 1'b1;
        @(negedge pclk);
        t_eng_rdata = 32'hCAFEF00D; t_eng_ack = 1'b1;
        t_wait(0, 1'b0);
        chk("t_good_req_drop", 32'(t_eng_req), 0);
        t_eng_ack = 1'b0;
        t_wait(1, 1'b1);
        chk("t_good_ack", 32'(t_c0_ack), 1);
        chk("t_good_rdata", t_c0_rdata, 32'hCAFEF00D);
        chk("t_good_err", 32'(t_err), 0);
        t_c0_req = 1'b0;
        t_wait(1, 1'b0);

        // Engine never acks
        @(negedge pclk);
        t_c0_wdata = 32'h33334444; t_c0_req = 1'b1;
        @(negedge pclk);
        n = 0;
        while (t_eng_req && n < 50) begin n++; @(negedge pclk); end
        chk("t_req_phase_cycles", 32'(n), 32'd8);
        chk("t_req_timeout_err", 32'(t_err), 1);
        t_wait(1, 1'b1);
        chk("t_to_ack", 32'(t_c0_ack), 1);
        chk("t_to_rdata_kept", t_c0_rdata, 32'hCAFEF00D);
        chk("t_to_c1_rdata", t_c1_rdata, 0);
        t_c0_req = 1'b0;
        t_wait(1, 1'b0);
        chk("t_err_sticky", 32'(t_err), 1);
        t_err_clr = 1'b1;
        @(negedge pclk);
        t_err_clr = 1'b0;
        chk("t_err_cleared", 32'(t_err), 0);

        // Engine ack stuck high after capture
        @(negedge pclk);
        t_c1_wdata = 32'hABCD0001; t_c1_req = 1'b1;
        @(negedge pclk);
        t_eng_rdata = 32'h55AA55AA; t_eng_ack = 1'b1;
        t_wait(0, 1'b0);
        chk("t_stuck_capture", 32'(t_eng_req), 0);
        n = 0;
        while (!t_c1_ack && n < 50) begin n++; @(negedge pclk); end
        chk("t_release_phase_cycles", 32'(n), 32'd8);
        chk("t_release_err", 32'(t_err), 1);
        chk("t_stuck_rdata", t_c1_rdata, 32'h55AA55AA);
        t_c1_req = 1'b0;
        t_wait(2, 1'b0);
        t_c0_wdata = 32'h0BAD0000; t_c0_req = 1'b1;
        n = 0;
        repeat (12) begin @(negedge pclk); if (t_eng_req) n++; end
        chk("t_no_req_while_ack", 32'(n), 0);
        chk("t_idle_while_ack", 32'(t_busy), 0);
        t_eng_ack = 1'b0;
        t_wait(0, 1'b1);
        chk("t_req_after_ack_low", 32'(t_eng_req), 1);
        chk("t_req_after_wdata", t_eng_wdata, 32'h0BAD0000);
        t_eng_rdata = 32'h12345678; t_eng_ack = 1'b1;
        t_wait(0, 1'b0);
        t_eng_ack = 1'b0;
        t_wait(1, 1'b1);
        chk("t_final_rdata", t_c0_rdata, 32'h12345678);
        t_c0_req = 1'b0;
        t_wait(1, 1'b0);
        chk("t_final_ack_low", 32'(t_c0_ack), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
